// File: rtl/twiddle_pkg.sv
// Shared types, defaults and the elaboration-time cosine table generator
// for the twiddle_gen block.
package twiddle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int TW_W_DEF = 18;
    localparam int FRAC_DEF = 8;

    // Returns round(cos(2*pi*i/n) * 2^frac) for 0 <= i <= n/4.
    // The result is produced with integer-only Q30 fixed-point arithmetic and a
    // Taylor series, so it folds to a constant at elaboration without real math.
    function automatic int twiddle_cos(input int i, input int n, input int frac);
        longint pi_s;
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint scaled;
        pi_s  = 64'sd3373259426;                 // pi * 2^30
        x     = (2 * pi_s * longint'(i)) / longint'(n);
        x2    = (x * x) >>> 30;
        term  = longint'(1) <<< 30;
        sum   = term;
        for (int unsigned k = 1; k <= 10; k++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * k - 1) * (2 * k)));
            sum  = sum + term;
        end
        scaled = (sum * (longint'(1) <<< frac)) + (longint'(1) <<< 29);
        return int'(scaled >>> 30);
    endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine table, Q+1 entries, with two registered read ports.
// Port a is addressed with r, port b with Q-r; both freeze when en is low.
module twiddle_qrom
    import twiddle_pkg::*;
#(
    parameter  int N_MAX = 96,
    parameter  int TW_W  = TW_W_DEF,
    parameter  int FRAC  = FRAC_DEF,
    localparam int Q     = N_MAX / 4,
    localparam int AW    = $clog2(Q + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [AW-1:0]          addr_a,
    input  logic [AW-1:0]          addr_b,
    output logic signed [TW_W-1:0] data_a,
    output logic signed [TW_W-1:0] data_b
);

    logic signed [TW_W-1:0] rom [Q+1];
    logic signed [TW_W-1:0] data_a_d;
    logic signed [TW_W-1:0] data_a_q;
    logic signed [TW_W-1:0] data_b_d;
    logic signed [TW_W-1:0] data_b_q;

    for (genvar i = 0; i <= Q; i++) begin : g_rom
        localparam int C = twiddle_cos(i, N_MAX, FRAC);
        assign rom[i] = TW_W'(C);
    end

    // Next read data: fetch both entries when enabled, otherwise hold.
    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (en) begin
            data_a_d = rom[addr_a];
            data_b_d = rom[addr_b];
        end
    end

    // Read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign data_a = data_a_q;
    assign data_b = data_b_q;

endmodule

// File: rtl/twiddle_gen.sv
// Streaming twiddle-factor generator: W = exp(-j*2*pi*p/N_MAX) for the phase
// sequence p0, p0+step, ... (mod N_MAX). Pipeline: phase issue -> quarter-wave
// ROM read -> quadrant symmetry/output register, with full-pipeline stall on
// backpressure.
// Optional feature macro: TWIDDLE_GEN_CONJ_EN adds cmd_conj, which conjugates
// the outputs of that command (inverse-transform twiddles).
module twiddle_gen
    import twiddle_pkg::*;
#(
    parameter  int N_MAX = 96,
    parameter  int TW_W  = TW_W_DEF,
    parameter  int FRAC  = FRAC_DEF,
    localparam int PW    = $clog2(N_MAX)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [PW-1:0]          cmd_start,
    input  logic [PW-1:0]          cmd_step,
    input  logic [PW:0]            cmd_count,
`ifdef TWIDDLE_GEN_CONJ_EN
    input  logic                   cmd_conj,
`endif
    output logic                   tw_valid,
    input  logic                   tw_ready,
    output logic signed [TW_W-1:0] tw_re,
    output logic signed [TW_W-1:0] tw_im,
    output logic                   tw_last,
    output logic                   busy
);

    localparam int Q  = N_MAX / 4;
    localparam int AW = $clog2(Q + 1);

    localparam logic [PW-1:0] Q1   = PW'(Q);
    localparam logic [PW-1:0] Q2   = PW'(2 * Q);
    localparam logic [PW-1:0] Q3   = PW'(3 * Q);
    localparam logic [PW:0]   NMAX = (PW + 1)'(N_MAX);
    localparam logic [PW:0]   ONE  = (PW + 1)'(1);

    // Command / control state
    state_e              state_d, state_q;
    logic                ready_d, ready_q;
    logic                busy_d, busy_q;
    logic [PW-1:0]       p_d, p_q;
    logic [PW-1:0]       step_d, step_q;
    logic [PW:0]         cnt_d, cnt_q;
    logic                conj_d, conj_q;

    // Stage 1 (ROM read) sideband
    logic                s1_valid_d, s1_valid_q;
    logic                s1_last_d, s1_last_q;
    logic [1:0]          s1_quad_d, s1_quad_q;

    // Stage 2 (output register)
    logic                tw_valid_d, tw_valid_q;
    logic                tw_last_d, tw_last_q;
    logic signed [TW_W-1:0] tw_re_d, tw_re_q;
    logic signed [TW_W-1:0] tw_im_d, tw_im_q;

    // Combinational helpers
    logic                en;
    logic                accept;
    logic                issue;
    logic                drain_done;
    logic [PW:0]         p_sum;
    logic [PW:0]         p_next;
    logic [1:0]          quad;
    logic [PW-1:0]       quad_base;
    logic [PW-1:0]       r;
    logic [AW-1:0]       addr_a;
    logic [AW-1:0]       addr_b;
    logic signed [TW_W-1:0] cos_r;
    logic signed [TW_W-1:0] cos_qr;
    logic signed [TW_W-1:0] sym_re;
    logic signed [TW_W-1:0] sym_im;

    // Handshake, stall and phase-accumulator arithmetic.
    always_comb begin
        en         = !(tw_valid_q && !tw_ready);
        accept     = cmd_valid && ready_q;
        issue      = (state_q == ST_RUN) && en;
        drain_done = tw_valid_q && tw_ready && tw_last_q;
        p_sum      = {1'b0, p_q} + {1'b0, step_q};
        p_next     = (p_sum >= NMAX) ? (p_sum - NMAX) : p_sum;
    end

    // Quadrant decode of the issued phase by comparison; r and Q-r address the ROM.
    always_comb begin
        quad      = 2'd0;
        quad_base = '0;
        if (p_q >= Q3) begin
            quad      = 2'd3;
            quad_base = Q3;
        end else if (p_q >= Q2) begin
            quad      = 2'd2;
            quad_base = Q2;
        end else if (p_q >= Q1) begin
            quad      = 2'd1;
            quad_base = Q1;
        end
        r      = p_q - quad_base;
        addr_a = AW'(r);
        addr_b = AW'(Q1 - r);
    end

    // Next-state logic for the command FSM, accumulator and remaining count.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        conj_d  = conj_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    p_d    = cmd_start;
                    step_d = cmd_step;
                    cnt_d  = cmd_count;
`ifdef TWIDDLE_GEN_CONJ_EN
                    conj_d = cmd_conj;
`else
                    conj_d = 1'b0;
`endif
                    state_d = (cmd_count != '0) ? ST_RUN : ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    p_d   = p_next[PW-1:0];
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Command FSM with registered cmd_ready/busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            p_q     <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            conj_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            p_q     <= p_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            conj_q  <= conj_d;
        end
    end

    twiddle_qrom #(
        .N_MAX (N_MAX),
        .TW_W  (TW_W),
        .FRAC  (FRAC)
    ) u_qrom (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .data_a (cos_r),
        .data_b (cos_qr)
    );

    // Quadrant symmetry on the ROM pair, then optional conjugation.
    always_comb begin
        unique case (s1_quad_q)
            2'd0: begin
                sym_re = cos_r;
                sym_im = -cos_qr;
            end
            2'd1: begin
                sym_re = -cos_qr;
                sym_im = -cos_r;
            end
            2'd2: begin
                sym_re = -cos_r;
                sym_im = cos_qr;
            end
            default: begin
                sym_re = cos_qr;
                sym_im = cos_r;
            end
        endcase
        if (conj_q) begin
            sym_im = -sym_im;
        end
    end

    // Pipeline advance: both stages move together unless the output is stalled.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_quad_d  = s1_quad_q;
        tw_valid_d = tw_valid_q;
        tw_last_d  = tw_last_q;
        tw_re_d    = tw_re_q;
        tw_im_d    = tw_im_q;
        if (en) begin
            s1_valid_d = issue;
            s1_last_d  = issue && (cnt_q == ONE);
            s1_quad_d  = quad;
            tw_valid_d = s1_valid_q;
            tw_last_d  = s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                tw_re_d = sym_re;
                tw_im_d = sym_im;
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_quad_q  <= '0;
            tw_valid_q <= 1'b0;
            tw_last_q  <= 1'b0;
            tw_re_q    <= '0;
            tw_im_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_quad_q  <= s1_quad_d;
            tw_valid_q <= tw_valid_d;
            tw_last_q  <= tw_last_d;
            tw_re_q    <= tw_re_d;
            tw_im_q    <= tw_im_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign tw_valid  = tw_valid_q;
    assign tw_last   = tw_last_q;
    assign tw_re     = tw_re_q;
    assign tw_im     = tw_im_q;

endmodule
